// File: rtl/nor_gate_if.sv
// Operand/result bundle for nor_gate. With NOR_GATE_TOGGLE_CNT_EN defined the
// bundle also carries the 16-bit c_q toggle counter.
interface nor_gate_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             any_high;
`ifdef NOR_GATE_TOGGLE_CNT_EN
  logic [15:0]      toggle_cnt;

  modport master (output a, b, input c, c_q, any_high, toggle_cnt);
  modport slave  (input a, b, output c, c_q, any_high, toggle_cnt);
`else
  modport master (output a, b, input c, c_q, any_high);
  modport slave  (input a, b, output c, c_q, any_high);
`endif
endinterface

// File: rtl/nor_gate.sv
// Bitwise two-input NOR with combinational and registered result plus a sticky
// "result ever high" flag. Optional c_q toggle counter via NOR_GATE_TOGGLE_CNT_EN.
module nor_gate_lane (
  input  logic a,
  input  logic b,
  output logic c
);
  assign c = ~(a | b);
endmodule

module nor_gate #(
  parameter int          WIDTH   = 1,
  parameter logic [63:0] RST_VAL = 64'd0
) (
  input  logic       clk,
  input  logic       rst,
  nor_gate_if.slave  bus
);
  logic [WIDTH-1:0] c_w;
  logic [WIDTH-1:0] c_q;
  logic             any_high;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nor_gate_lane u_lane (
      .a (bus.a[i]),
      .b (bus.b[i]),
      .c (c_w[i])
    );
  end

  assign bus.c        = c_w;
  assign bus.c_q      = c_q;
  assign bus.any_high = any_high;

  // any_high looks at the previous c_q, so it trails c_q by one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q      <= RST_VAL[WIDTH-1:0];
      any_high <= 1'b0;
    end else begin
      c_q      <= c_w;
      any_high <= any_high | (|c_q);
    end
  end

`ifdef NOR_GATE_TOGGLE_CNT_EN
  logic [15:0] toggle_cnt;

  // c_w != c_q means c_q is about to change at this edge; reset loads are never counted
  always_ff @(posedge clk) begin
    if (rst)
      toggle_cnt <= 16'd0;
    else if ((c_w != c_q) && (toggle_cnt != 16'hFFFF))
      toggle_cnt <= toggle_cnt + 16'd1;
  end

  assign bus.toggle_cnt = toggle_cnt;
`endif
endmodule

// File: tb/tb_nor_gate.sv
// Directed, table-driven bench for nor_gate: WIDTH=1, WIDTH=8 and a WIDTH=4
// instance with a wide RST_VAL to check truncation of the reset value.
module tb_nor_gate;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  nor_gate_if #(.WIDTH(1)) if1 ();
  nor_gate_if #(.WIDTH(8)) if8 ();
  nor_gate_if #(.WIDTH(4)) if4 ();

  nor_gate #(.WIDTH(1), .RST_VAL(64'd0))   u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  nor_gate #(.WIDTH(8), .RST_VAL(64'd0))   u8 (.clk(clk), .rst(rst), .bus(if8.slave));
  nor_gate #(.WIDTH(4), .RST_VAL(64'hF9))  u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  // u4 follows the low nibble of the 8-bit operands
  assign if4.a = if8.a[3:0];
  assign if4.b = if8.b[3:0];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } vec_t;

  vec_t tbl1 [4];
  vec_t tbl8 [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl1[0] = '{8'h0, 8'h0, 8'h1};
    tbl1[1] = '{8'h0, 8'h1, 8'h0};
    tbl1[2] = '{8'h1, 8'h0, 8'h0};
    tbl1[3] = '{8'h1, 8'h1, 8'h0};
    tbl8[0] = '{8'hF0, 8'h0C, 8'h03};
    tbl8[1] = '{8'h00, 8'h00, 8'hFF};
    tbl8[2] = '{8'hFF, 8'h00, 8'h00};
    tbl8[3] = '{8'hAA, 8'h55, 8'h00};
    tbl8[4] = '{8'hA0, 8'h05, 8'h5A};
    tbl8[5] = '{8'h12, 8'h34, 8'hC9};

    if1.a = 1'b0; if1.b = 1'b0;
    if8.a = 8'h00; if8.b = 8'h00;

    // reset held for two edges with zero operands
    rst = 1'b1;
    tick(); tick();
    chk("rst_c8",       if8.c, 8'hFF);
    chk("rst_cq8",      if8.c_q, 8'h00);
    chk("rst_any8",     if8.any_high, 1'b0);
    chk("rst_cq4",      if4.c_q, 4'h9);
    chk("rst_any4",     if4.any_high, 1'b0);
    chk("rst_cq1",      if1.c_q, 1'b0);
    rst = 1'b0;
    tick();
    chk("rel_cq8",      if8.c_q, 8'hFF);
    chk("rel_any8_lag", if8.any_high, 1'b0);
    chk("rel_any4",     if4.any_high, 1'b1);
    tick();
    chk("rel_any8",     if8.any_high, 1'b1);

    // all-ones operands keep any_high low until a single zero cycle
    rst = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("ones_c8",      if8.c, 8'h00);
    chk("ones_cq8",     if8.c_q, 8'h00);
    chk("ones_any8",    if8.any_high, 1'b0);
    if8.a = 8'h00; if8.b = 8'h00;
    tick();
    chk("pulse_cq8",    if8.c_q, 8'hFF);
    chk("pulse_any8",   if8.any_high, 1'b0);
    if8.a = 8'hFF; if8.b = 8'hFF;
    tick();
    chk("post_cq8",     if8.c_q, 8'h00);
    chk("post_any8",    if8.any_high, 1'b1);
    tick();
    chk("sticky_any8",  if8.any_high, 1'b1);

    // WIDTH=1 truth table, 5-unit steps, combinational only
    for (int i = 0; i < 4; i++) begin
      if1.a = tbl1[i].a[0]; if1.b = tbl1[i].b[0];
      #1 chk($sformatf("tt1_%0d", i), if1.c, tbl1[i].c[0]);
      #4;
    end

    // WIDTH=8 vectors: immediate c, then c_q after the next edge
    for (int i = 0; i < 6; i++) begin
      if8.a = tbl8[i].a; if8.b = tbl8[i].b;
      #1 chk($sformatf("vec8_c_%0d", i), if8.c, tbl8[i].c);
      chk($sformatf("vec4_c_%0d", i), if4.c, tbl8[i].c[3:0]);
      tick();
      chk($sformatf("vec8_cq_%0d", i), if8.c_q, tbl8[i].c);
    end

    // reset coinciding with an input change that makes c nonzero
    if8.a = 8'hFF; if8.b = 8'hFF;
    tick();
    rst = 1'b1; if8.a = 8'h00; if8.b = 8'h00;
    #1;
    chk("co_c8_now",    if8.c, 8'hFF);
    chk("co_cq8_hold",  if8.c_q, 8'h00);
    chk("co_any8_hold", if8.any_high, 1'b1);
    tick();
    chk("co_cq8",       if8.c_q, 8'h00);
    chk("co_any8",      if8.any_high, 1'b0);
    chk("co_cq4",       if4.c_q, 4'h9);
    chk("co_any4",      if4.any_high, 1'b0);

`ifdef NOR_GATE_TOGGLE_CNT_EN
    // a alternates 1,0,1,0,1 (b=0): first edge leaves c_q at 0, next four toggle it
    rst = 1'b1; if1.a = 1'b1; if1.b = 1'b0;
    tick();
    chk("tog_rst",      if1.toggle_cnt, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if1.a = (i % 2 == 0);
      tick();
    end
    chk("tog_cnt",      if1.toggle_cnt, 16'd4);
    rst = 1'b1;
    tick();
    chk("tog_clr",      if1.toggle_cnt, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nor_gate.md
Name: nor_gate

Overview:
- Parameterised bitwise two-input NOR.
- Output c is purely combinational, so it responds with zero latency to a and b.
- Also provides a registered copy of the result, plus a sticky "result ever high" flag for downstream synchronous logic.
- Leaf cell used wherever a NOR of two buses, or a clock-aligned NOR, is needed.

Parameters:
- WIDTH, 1: bit width of a, b, c and c_q; legal range 1..64.
- RST_VAL, 0: value loaded into c_q on reset; only bits [WIDTH-1:0] are used.

Ports:
- clk  input  1  rising-edge clock for all registered state.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  output  WIDTH  combinational result, ~(a | b), bitwise.
- c_q  output  WIDTH  registered result, c sampled on each rising clk edge.
- any_high  output  1  sticky flag; set once any bit of c_q has been 1 since reset.

Behaviour:
- Combinational output c:
  - c[i] = ~(a[i] | b[i]) for every bit i.
  - Independent of clk and rst; valid whenever a and b are valid.
  - Truth table per bit: 00->1, 01->0, 10->0, 11->0.
  - X or Z on an input bit propagates per standard 4-state NOR rules: a 1 on either input forces 0, otherwise X.
- Registered output c_q:
  - On each rising edge, if rst=1, c_q <= RST_VAL[WIDTH-1:0].
  - Otherwise c_q <= c.
  - One-cycle latency from a/b to c_q.
- any_high flag:
  - On a rising edge with rst=1, any_high <= 0.
  - Otherwise any_high <= any_high | (|c_q).
  - It therefore rises one cycle after c_q first contains a 1, and stays high until the next reset.
- Reset:
  - Reset asserted mid-operation takes effect at the next edge only; c is never affected.
  - If rst and an input change coincide at an edge, reset wins for c_q and any_high.
- No handshake and no internal state machine beyond the registers above.

Optional Feature:
- Macro: NOR_GATE_TOGGLE_CNT_EN.
- When defined, the block adds output toggle_cnt, 16 bits:
  - Counts rising edges (rst=0) where c_q changes value relative to its previous value.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared to 0 on synchronous reset.
  - A change caused by reset itself is not counted.
- When undefined, toggle_cnt does not exist as a port and no counter logic is built.

Test Plan:
- WIDTH=1, apply a/b = 00, 01, 10, 11 at 5-time-unit steps -> c = 1, 0, 0, 0, each immediately after the input change.
- WIDTH=8, rst=0, a=8'hF0, b=8'h0C -> c=8'h03; c_q=8'h03 after the next rising edge; any_high=1 one edge later.
- Hold rst=1 for 2 edges with a=b=0 and RST_VAL=0 -> c=all ones combinationally, c_q=0, any_high=0. Release rst -> c_q=all ones after 1 edge.
- Drive a=b=all ones for 10 edges after reset -> c=0, c_q=0, any_high stays 0. Then one cycle of a=b=0 -> any_high=1 and remains 1 after a and b return to all ones.
- Assert rst in the same cycle as an input change making c nonzero -> c updates immediately; c_q=RST_VAL and any_high=0 at that edge.
- With NOR_GATE_TOGGLE_CNT_EN defined, alternate a between 0 and 1 (b=0, WIDTH=1) every cycle for 5 edges after reset -> toggle_cnt=4 (the first post-reset edge loads an unchanged or initial value; subsequent alternations each count once). Asserting rst -> toggle_cnt=0.
